// File: rtl/my_interface1_sys_pkg.sv
// rtl/my_interface1_sys_pkg.sv - shared types and constants for the serial frame receiver
package my_interface1_sys_pkg;

    typedef logic [7:0] t_byte;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } t_state;

    localparam t_byte IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/my_interface1.sv
// rtl/my_interface1.sv - serial line in, frame-done strobe out
interface my_interface1;

    logic one;
    logic two;

    modport sys (input one, output two);

endinterface

// File: rtl/my_interface1_sys_baud.sv
// rtl/my_interface1_sys_baud.sv - bit-period counter with mid-bit sample and end-of-bit flags
module my_interface1_sys_baud #(
    parameter int P1 = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sample_pulse,
    output logic bit_end
);

    localparam logic [15:0] LAST = 16'(P1);
    localparam logic [15:0] HALF = 16'(P1 / 2);

    logic [15:0] cnt;

    assign sample_pulse = (cnt == HALF);
    assign bit_end      = (cnt == LAST);

    // Held at zero while idle so the detect edge is count 0 of the start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/my_interface1_sys.sv
// rtl/my_interface1_sys.sv - 8N1 frame receiver with done strobe and framing-error pulse
module my_interface1_sys
    import my_interface1_sys_pkg::*;
#(
    parameter int P1 = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  one,
    output logic  two,
    output t_byte rx_byte,
    output logic  frame_err
);

    my_interface1 bus ();

    t_state     state;
    t_state     state_next;
    logic [2:0] bit_idx;
    t_byte      shreg;
    logic       done_q;
    logic       sample_pulse;
    logic       bit_end;
    logic       run;

    assign bus.one = one;
    assign bus.two = done_q;
    assign two     = bus.two;
    assign run     = (state_next != IDLE);

    my_interface1_sys_baud #(.P1(P1)) u_baud (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .sample_pulse (sample_pulse),
        .bit_end      (bit_end)
    );

    // With a one-cycle bit the detect edge is also the start sample, so skip START.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!bus.one) state_next = (sample_pulse && bit_end) ? DATA : START;
            START: begin
                if (sample_pulse && bus.one) state_next = IDLE;
                else if (bit_end)            state_next = DATA;
            end
            DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (sample_pulse) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_idx   <= 3'd0;
            shreg     <= IDLE_BYTE;
            rx_byte   <= IDLE_BYTE;
            done_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            done_q    <= 1'b0;
            frame_err <= 1'b0;
            if (state == DATA) begin
                if (sample_pulse) shreg[bit_idx] <= bus.one;
                if (bit_end)      bit_idx <= bit_idx + 3'd1;
            end
            if (state == STOP && sample_pulse) begin
                if (bus.one) begin
                    rx_byte <= shreg;
                    done_q  <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_my_interface1_sys.sv
// tb/tb_my_interface1_sys.sv - directed and random frames against a frame-level reference model
`timescale 1ns/1ps
module tb_my_interface1_sys;
    import my_interface1_sys_pkg::*;

    typedef struct {
        int         inst;
        int         cyc;
        bit         err;
        logic [7:0] b;
    } ev_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  one0 = 1'b1;
    logic  one3 = 1'b1;
    logic  two0, two3, err0, err3;
    t_byte rx0, rx3;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    ev_t        got[$];
    ev_t        exp_q[$];
    logic [7:0] exp_rx [2];
    logic [7:0] rd;
    int         rinst, rgap;
    bit         rstop;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    my_interface1_sys #(.P1(0)) d0 (
        .clk(clk), .rst(rst), .one(one0), .two(two0), .rx_byte(rx0), .frame_err(err0)
    );
    my_interface1_sys #(.P1(3)) d3 (
        .clk(clk), .rst(rst), .one(one3), .two(two3), .rx_byte(rx3), .frame_err(err3)
    );

    always @(negedge clk) begin
        if (two0 || err0) begin
            n_cmp++;
            assert (!(two0 && err0)) else begin
                n_bad++;
                $error("FAIL excl0: two=%b frame_err=%b expected not both", two0, err0);
            end
            got.push_back('{0, cyc, err0, rx0});
        end
        if (two3 || err3) begin
            n_cmp++;
            assert (!(two3 && err3)) else begin
                n_bad++;
                $error("FAIL excl3: two=%b frame_err=%b expected not both", two3, err3);
            end
            got.push_back('{1, cyc, err3, rx3});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_line(input int inst, input logic v);
        if (inst == 0) one0 = v;
        else           one3 = v;
    endtask

    task automatic idle(input int inst, input int n);
        set_line(inst, 1'b1);
        repeat (n) @(negedge clk);
    endtask

    // Drives nb bits of a frame; a full frame's event time follows from the bit period alone.
    task automatic send(input int inst, input logic [7:0] d, input logic stop, input int nb);
        logic [9:0] bits;
        int         per, c;
        bits = {stop, d, 1'b0};
        per  = (inst == 0) ? 1 : 4;
        c    = cyc;
        for (int i = 0; i < nb; i++) begin
            set_line(inst, bits[i]);
            repeat ((i == 9) ? (per - 1) / 2 + 1 : per) @(negedge clk);
        end
        if (nb == 10) begin
            exp_q.push_back('{inst, c + 1 + 9 * per + (per - 1) / 2, !stop,
                              stop ? d : exp_rx[inst]});
            if (stop) exp_rx[inst] = d;
        end
    endtask

    task automatic check_events(input string tag);
        n_cmp++;
        assert (got.size() === exp_q.size()) else begin
            n_bad++;
            $error("FAIL %s count: observed %0d expected %0d", tag, got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            assert (got[i].inst === exp_q[i].inst && got[i].cyc === exp_q[i].cyc &&
                    got[i].err === exp_q[i].err && got[i].b === exp_q[i].b) else begin
                n_bad++;
                $error("FAIL %s ev%0d: observed inst%0d cyc%0d err%0d byte%h expected inst%0d cyc%0d err%0d byte%h",
                       tag, i, got[i].inst, got[i].cyc, got[i].err, got[i].b,
                       exp_q[i].inst, exp_q[i].cyc, exp_q[i].err, exp_q[i].b);
            end
        end
        chk({tag, " rx0"}, 32'(rx0), 32'(exp_rx[0]));
        chk({tag, " rx3"}, 32'(rx3), 32'(exp_rx[1]));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        exp_rx[0] = 8'hFF;
        exp_rx[1] = 8'hFF;
        repeat (3) @(negedge clk);
        chk("reset rx0", 32'(rx0), 32'hFF);
        chk("reset rx3", 32'(rx3), 32'hFF);
        chk("reset two0", 32'(two0), 32'h0);
        chk("reset two3", 32'(two3), 32'h0);
        chk("reset err0", 32'(err0), 32'h0);
        chk("reset err3", 32'(err3), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(0, 8'hA5, 1'b1, 10);
        idle(0, 4);
        check_events("a5_p0");

        send(1, 8'h12, 1'b0, 10);
        idle(1, 6);
        check_events("stoperr_p3");

        send(1, 8'h3C, 1'b1, 10);
        idle(1, 6);
        check_events("3c_p3");

        set_line(1, 1'b0);
        @(negedge clk);
        idle(1, 1);
        idle(1, 6);
        check_events("glitch_p3");
        set_line(1, 1'b0);
        @(negedge clk);
        idle(1, 1);
        send(1, 8'h81, 1'b1, 10);
        idle(1, 6);
        check_events("after_glitch_p3");

        send(0, 8'h5A, 1'b1, 5);
        set_line(0, 1'b1);
        #2 rst = 1'b1;
        #1;
        exp_rx[0] = 8'hFF;
        exp_rx[1] = 8'hFF;
        chk("async rx0", 32'(rx0), 32'hFF);
        chk("async two0", 32'(two0), 32'h0);
        chk("async err0", 32'(err0), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(0, 2);
        check_events("abort_p0");
        send(0, 8'h5A, 1'b1, 10);
        idle(0, 4);
        check_events("5a_p0");

        send(0, 8'h01, 1'b1, 10);
        send(0, 8'hFE, 1'b1, 10);
        idle(0, 4);
        if (got.size() == 2) chk("b2b spacing", 32'(got[1].cyc - got[0].cyc), 32'd10);
        check_events("b2b_p0");

        for (int k = 0; k < 16; k++) begin
            rinst = int'($urandom_range(0, 1));
            rd    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            send(rinst, rd, rstop, 10);
            rgap = int'($urandom_range(0, 3));
            idle(rinst, rgap);
        end
        idle(0, 8);
        idle(1, 8);
        check_events("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/my_interface1_sys.md
MY_INTERFACE1_SYS -- requirements
Module: my_interface1_sys

Interface
REQ-001 Parameter P1: int, default 0; bit period minus one, in clk cycles, so one bit lasts P1+1 cycles; legal range 0..65535.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 one  input  1  serial line (modport sys "one"); synchronous to clk; idles high.
REQ-005 two  output 1  frame-done strobe (modport sys "two"); one-cycle pulse per good frame.
REQ-006 rx_byte  output  8 (t_byte)  last correctly received data byte.
REQ-007 frame_err  output  1  one-cycle pulse when a stop bit samples low.

Function
REQ-008 The block SHALL receive frames of 1 start bit (0), 8 data bits LSB first and 1 stop bit (1) on "one".
REQ-009 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-010 In IDLE, one==0 sampled at an edge SHALL start a frame; that edge is clock 0 of the start bit.
REQ-011 A bit counter SHALL run 0..P1 per bit; each bit SHALL be sampled at count P1/2 (floor), with the start bit counted from the detect edge.
REQ-012 With P1==0, the detect edge itself SHALL be the start-bit sample, and the FSM SHALL go directly to DATA.
REQ-013 START: one==1 at the start-bit sample SHALL be a false start -> IDLE, with no output change.
REQ-014 DATA: sample k (k=0..7) SHALL be written to bit k of an internal shift register; after sample 7 -> STOP.
REQ-015 STOP, one==1 at the sample: rx_byte SHALL load the assembled byte and two SHALL be 1 for exactly the next cycle.
REQ-016 STOP, one==0 at the sample: frame_err SHALL be 1 for exactly the next cycle, and rx_byte SHALL hold its value.
REQ-017 After the stop-bit sample the FSM SHALL enter IDLE immediately, so a start bit beginning the next cycle is accepted (back-to-back frames).
REQ-018 Latency SHALL be one cycle from the stop-bit sample edge to two/frame_err high; two and frame_err SHALL never be high together.
REQ-019 two, rx_byte and frame_err SHALL be driven directly from flops, with no combinational path from "one".
REQ-020 No input synchronizer SHALL be included; the integrator guarantees "one" is synchronous to clk.

Reset
REQ-021 While rst=1, state SHALL be IDLE, the counters 0, the shift register 8'hFF, rx_byte 8'hFF, two 0 and frame_err 0.
REQ-022 rst asserted mid-frame SHALL abort the frame, with no strobe and no rx_byte update.
REQ-023 After rst deasserts, the first edge with one==0 SHALL start a new frame.

Structure
REQ-024 Package my_interface1_sys_pkg SHALL hold typedef t_byte (logic[7:0]), the FSM state enum and constant IDLE_BYTE = 8'hFF.
REQ-025 The bit-period counter SHALL be sub-module my_interface1_sys_baud, parameterized by P1, outputting sample_pulse and bit_end.
REQ-026 The top SHALL connect to the sys modport of my_interface1, with "one" as input and "two" as output.

Verification
REQ-027 P1=0; drive 0, then A5 LSB first (1,0,1,0,0,1,0,1), then 1 -> two high exactly one cycle, one cycle after the stop edge; rx_byte=8'hA5; frame_err=0.
REQ-028 P1=3; frame 8'h3C, each bit held 4 cycles -> rx_byte=8'h3C, two one pulse; sampling at count 1 of each bit.
REQ-029 P1=3; frame 8'h12 with stop bit 0 -> frame_err one pulse; two=0; rx_byte keeps its prior value (8'hFF after reset).
REQ-030 P1=3; one low for 1 cycle only (glitch) -> false start; no strobes; FSM back in IDLE.
REQ-031 P1=0; assert rst during data bit 4 of a frame -> outputs at reset values immediately (asynchronous); the next full frame 8'h5A is received correctly.
REQ-032 P1=0; frames 8'h01 and 8'hFE back-to-back with no idle gap -> two pulses 10 cycles apart; rx_byte 8'h01 then 8'hFE.
